// File: rtl/conv_seq_ctrl_if.sv
// Purpose: host, X/Y/Z memory and MAC signal bundle of the convolution sequencer.
// Latency: none; wires only.
// Backpressure: z_ready is the only flow-control input; z_we is held while it is low.
// Ports: start/mode/len_x/len_y (host request), rd_en/x_addr/y_addr (X/Y reads),
//        mac_en/mac_first (MAC strobes), z_we/z_ready/z_addr (Z write),
//        busy/done/err (host status).
// master = controller side, slave = host + memories + MAC side.
interface conv_seq_ctrl_if #(
    parameter int AW = 5
) ();
    logic          start;
    logic          mode;
    logic [AW-1:0] len_x;
    logic [AW-1:0] len_y;
    logic          rd_en;
    logic [AW-1:0] x_addr;
    logic [AW-1:0] y_addr;
    logic          mac_en;
    logic          mac_first;
    logic          z_we;
    logic          z_ready;
    logic [AW:0]   z_addr;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, mode, len_x, len_y, z_ready,
        output rd_en, x_addr, y_addr, mac_en, mac_first, z_we, z_addr, busy, done, err
    );

    modport slave (
        output start, mode, len_x, len_y, z_ready,
        input  rd_en, x_addr, y_addr, mac_en, mac_first, z_we, z_addr, busy, done, err
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Purpose: j/k loop sequencer for z[k] = sum x[j]*y[k-j] in FULL or SAME mode.
// Latency: busy the cycle after start; per output n_k + RD_LAT + MAC_LAT + 2 cycles.
// Backpressure: z_we/z_addr held while z_ready is low; no reads are issued meanwhile.
// Ports: clk, rst_n (async active-low); bus (master modport) carries the host
//        request/status, X/Y read strobe and addresses, MAC strobes and Z write.
module conv_seq_ctrl #(
    parameter int AW      = 5,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    conv_seq_ctrl_if.master bus
);
    // AW+2 bits hold Lx+Ly-2 and the k+1 comparisons without overflow.
    localparam int W  = AW + 2;
    localparam int ZW = AW + 1;
    localparam int DW = $clog2(RD_LAT + MAC_LAT + 1);
    localparam logic [W-1:0]  ONE        = W'(1);
    localparam logic [W-1:0]  TWO        = W'(2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT + MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ROW, S_ACC, S_DRAIN, S_WRITE, S_FIN
    } state_e;

    state_e            state_q;
    logic              mode_q;
    logic [W-1:0]      lx_q, ly_q;
    logic [W-1:0]      k_q, kend_q, koff_q;
    logic [W-1:0]      j_q, jhi_q;
    logic [DW-1:0]     drain_q;
    logic              rd_en_q, first_q;
    logic [AW-1:0]     y_addr_q;
    logic              z_we_q;
    logic [ZW-1:0]     z_addr_q;
    logic              busy_q, done_q, err_q;
    logic [RD_LAT-1:0] dl_en_q, dl_first_q;

    // Valid j range for the current k: jlo = max(0, k-(Ly-1)), jhi = min(k, Lx-1).
    // k+1 > Ly is the unsigned form of k-(Ly-1) > 0.
    logic [W-1:0] row_jlo, row_jhi;
    always_comb begin
        row_jlo = '0;
        if (k_q + ONE > ly_q) begin
            row_jlo = k_q + ONE - ly_q;
        end
        row_jhi = (k_q < lx_q - ONE) ? k_q : lx_q - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            lx_q     <= '0;
            ly_q     <= '0;
            k_q      <= '0;
            kend_q   <= '0;
            koff_q   <= '0;
            j_q      <= '0;
            jhi_q    <= '0;
            drain_q  <= '0;
            rd_en_q  <= 1'b0;
            first_q  <= 1'b0;
            y_addr_q <= '0;
            z_we_q   <= 1'b0;
            z_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // done/err are single-cycle pulses.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        lx_q   <= {2'b00, bus.len_x};
                        ly_q   <= {2'b00, bus.len_y};
                        if (bus.len_x == '0 || bus.len_y == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_SETUP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (mode_q) begin
                        // SAME: centred window, floor offset for even Ly.
                        koff_q <= (ly_q - ONE) >> 1;
                        k_q    <= (ly_q - ONE) >> 1;
                        kend_q <= ((ly_q - ONE) >> 1) + lx_q - ONE;
                    end else begin
                        koff_q <= '0;
                        k_q    <= '0;
                        kend_q <= lx_q + ly_q - TWO;
                    end
                    state_q <= S_ROW;
                end
                S_ROW: begin
                    j_q      <= row_jlo;
                    jhi_q    <= row_jhi;
                    y_addr_q <= AW'(k_q - row_jlo);
                    rd_en_q  <= 1'b1;
                    first_q  <= 1'b1;
                    state_q  <= S_ACC;
                end
                S_ACC: begin
                    first_q <= 1'b0;
                    if (j_q == jhi_q) begin
                        rd_en_q <= 1'b0;
                        drain_q <= DRAIN_LAST;
                        state_q <= S_DRAIN;
                    end else begin
                        j_q      <= j_q + ONE;
                        y_addr_q <= y_addr_q - AW'(1);
                    end
                end
                S_DRAIN: begin
                    // Lets the read pipe empty and the MAC settle before writing.
                    if (drain_q == '0) begin
                        z_we_q   <= 1'b1;
                        z_addr_q <= ZW'(k_q - koff_q);
                        state_q  <= S_WRITE;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                S_WRITE: begin
                    if (bus.z_ready) begin
                        z_we_q <= 1'b0;
                        if (k_q == kend_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            k_q     <= k_q + ONE;
                            state_q <= S_ROW;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency delay line: strobe and first-term tag travel with the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_en_q    <= '0;
            dl_first_q <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                dl_en_q[i]    <= dl_en_q[i-1];
                dl_first_q[i] <= dl_first_q[i-1];
            end
            dl_en_q[0]    <= rd_en_q;
            dl_first_q[0] <= rd_en_q & first_q;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.x_addr    = j_q[AW-1:0];
    assign bus.y_addr    = y_addr_q;
    assign bus.mac_en    = dl_en_q[RD_LAT-1];
    assign bus.mac_first = dl_first_q[RD_LAT-1];
    assign bus.z_we      = z_we_q;
    assign bus.z_addr    = z_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
